vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters: the scanline pixel fetch (display side, fed by the hvsync timing generator) and the CPU/host write-read port.
- Display has absolute priority; the CPU uses free cycles.
- Sits between the hvsync/pixel pipeline and the VRAM macro, in the pixel-clock domain.
- Includes a saturating stall counter for bandwidth debugging.

---
 rtl/vram_arbiter_if.sv | 73 +++++++
 rtl/vram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Bundle of requester, RAM and statistics signals that connect
//               the VRAM arbiter to the display fetch, the CPU port and the
//               single-port VRAM macro.
//               slave  modport : arbiter side (takes requests, drives RAM)
//               master modport : environment side (requesters + RAM model)
// Ports       : display_on, disp_req/addr/gnt/rdata/valid,
//               cpu_req/we/addr/wdata/gnt/rdata/valid,
//               mem_en/we/addr/wdata/rdata, stat_clr, stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
);
    // Timing-generator side
    logic               display_on;

    // Display fetch port
    logic               disp_req;
    logic [ADDR_W-1:0]  disp_addr;
    logic               disp_gnt;
    logic [DATA_W-1:0]  disp_rdata;
    logic               disp_valid;

    // CPU / host port
    logic               cpu_req;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_gnt;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_valid;

    // VRAM macro port
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    // Bandwidth statistics
    logic               stat_clr;
    logic [STALL_W-1:0] stall_cnt;

    modport slave (
        input  display_on,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rdata, disp_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        input  stat_clr,
        output stall_cnt
    );

    modport master (
        output display_on,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rdata, disp_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        output stat_clr,
        input  stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Arbitrates one single-port synchronous VRAM between the
//               scanline display fetch (absolute priority) and the CPU port
//               (uses free cycles). Grant in cycle N, RAM command in N+1,
//               read return in N+2; one grant per cycle sustained.
//               A saturating counter records CPU stall cycles.
// Ports       : clk    - pixel clock
//               reset  - asynchronous, active-low reset
//               bus    - vram_arbiter_if.slave (requesters, RAM, statistics)
// Options     : VRAM_ARB_BLANK_ONLY_EN - when defined, the CPU is only
//               granted while display_on is low (blanking intervals).
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    vram_arbiter_if.slave       bus
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic c_OWN_DISP = 1'b0;
    localparam logic c_OWN_CPU  = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_RD_PEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------------
    logic w_cpu_allowed;
    logic w_disp_gnt;
    logic w_cpu_gnt;

`ifdef VRAM_ARB_BLANK_ONLY_EN
    // CPU traffic is confined to blanking so active-region fetches never
    // sit next to a CPU access on the RAM bus.
    assign w_cpu_allowed = ~bus.display_on;
`else
    wire w_unused_display_on = bus.display_on;
    assign w_cpu_allowed = 1'b1;
`endif

    // Nothing is accepted while reset is held, so grants stay low then and a
    // held CPU request is simply re-arbitrated once reset is released.
    assign w_disp_gnt = reset & bus.disp_req;
    assign w_cpu_gnt  = reset & bus.cpu_req & ~bus.disp_req & w_cpu_allowed;

    assign bus.disp_gnt = w_disp_gnt;
    assign bus.cpu_gnt  = w_cpu_gnt;

    // ------------------------------------------------------------------------
    // Command stage: registered RAM command, one cycle after the grant
    // ------------------------------------------------------------------------
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cmd_owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cmd_owner <= c_OWN_DISP;
        end else begin
            r_mem_en <= w_disp_gnt | w_cpu_gnt;
            r_mem_we <= w_cpu_gnt & bus.cpu_we;
            // Address/data only move on a grant; idle cycles hold them so
            // the RAM bus does not toggle needlessly.
            if (w_disp_gnt) begin
                r_mem_addr  <= bus.disp_addr;
                r_cmd_owner <= c_OWN_DISP;
            end else if (w_cpu_gnt) begin
                r_mem_addr  <= bus.cpu_addr;
                r_mem_wdata <= bus.cpu_wdata;
                r_cmd_owner <= c_OWN_CPU;
            end
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------------
    // Return stage: read-owner FSM
    // RD_PEND means the RAM is presenting read data this cycle for the
    // requester held in r_owner. A read command on the bus in cycle N+1
    // moves the FSM to RD_PEND for cycle N+2, matching the RAM latency.
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_rd_cmd;
    logic   w_rd_ret;

    assign w_rd_cmd = r_mem_en & ~r_mem_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= c_OWN_DISP;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_cmd) begin
                r_owner <= r_cmd_owner;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_ret    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_cmd) begin
                    w_state_nxt = S_RD_PEND;
                end
            end
            S_RD_PEND: begin
                w_rd_ret = 1'b1;
                // Back-to-back reads keep the FSM here, one return per cycle.
                if (w_rd_cmd) begin
                    w_state_nxt = S_RD_PEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    logic w_disp_valid;
    logic w_cpu_valid;

    assign w_disp_valid = w_rd_ret & (r_owner == c_OWN_DISP);
    assign w_cpu_valid  = w_rd_ret & (r_owner == c_OWN_CPU);

    assign bus.disp_valid = w_disp_valid;
    assign bus.cpu_valid  = w_cpu_valid;

    // Read data is passed through only to the owner of the return, so the
    // idle data buses are quiet and reset drives them to zero.
    assign bus.disp_rdata = w_disp_valid ? bus.mem_rdata : '0;
    assign bus.cpu_rdata  = w_cpu_valid  ? bus.mem_rdata : '0;

    // ------------------------------------------------------------------------
    // Saturating CPU stall counter
    // ------------------------------------------------------------------------
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_stall;

    assign w_stall = bus.cpu_req & ~w_cpu_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (bus.stat_clr) begin
            // Clear wins over a coincident stall.
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter. A behavioural
//               single-port RAM with 1-cycle read latency sits on the mem_*
//               side; its contents start as addr[7:0] ^ 8'h5A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int STALL_W = 4;

`ifdef VRAM_ARB_BLANK_ONLY_EN
    localparam logic c_BLANK_ONLY = 1'b1;
`else
    localparam logic c_BLANK_ONLY = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) bus_if ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural VRAM
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_mem_q;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = DATA_W'(i) ^ 8'h5A;
        end
        r_mem_q = '0;
    end

    always @(posedge clk) begin
        if (bus_if.mem_en) begin
            if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
            else               r_mem_q <= mem[bus_if.mem_addr];
        end
    end

    assign bus_if.mem_rdata = r_mem_q;

    // Inputs change 1 time unit after the rising edge; checks follow at +2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.display_on = 1'b0;
        bus_if.disp_req   = 1'b0;
        bus_if.disp_addr  = '0;
        bus_if.cpu_req    = 1'b0;
        bus_if.cpu_we     = 1'b0;
        bus_if.cpu_addr   = '0;
        bus_if.cpu_wdata  = '0;
        bus_if.stat_clr   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [48:0] obs;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_if.disp_req   = 1'($urandom);
            bus_if.disp_addr  = ADDR_W'($urandom);
            bus_if.cpu_req    = 1'($urandom);
            bus_if.cpu_we     = 1'($urandom);
            bus_if.cpu_addr   = ADDR_W'($urandom);
            bus_if.cpu_wdata  = DATA_W'($urandom);
            bus_if.stat_clr   = 1'($urandom);
            bus_if.display_on = 1'($urandom);
            #1;
            obs = {bus_if.mem_en, bus_if.mem_we, bus_if.disp_valid, bus_if.cpu_valid,
                   bus_if.disp_gnt, bus_if.cpu_gnt, bus_if.mem_addr, bus_if.mem_wdata,
                   bus_if.stall_cnt, bus_if.disp_rdata, bus_if.cpu_rdata};
            checks++;
            if (obs !== 49'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", i, obs);
            end
        end
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if ({bus_if.mem_en, bus_if.disp_gnt, bus_if.cpu_gnt, bus_if.disp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 0000",
                     {bus_if.mem_en, bus_if.disp_gnt, bus_if.cpu_gnt, bus_if.disp_valid});
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_display_read();
        tick();
        bus_if.disp_req  = 1'b1;
        bus_if.disp_addr = 15'h0123;
        #1;
        checks++;
        if ({bus_if.disp_gnt, bus_if.cpu_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL disp_grant: got %b want 10", {bus_if.disp_gnt, bus_if.cpu_gnt});
        end
        tick();
        bus_if.disp_req = 1'b0;
        #1;
        checks++;
        if ({bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.disp_valid} !== {2'b10, 15'h0123, 1'b0}) begin
            errors++;
            $display("FAIL disp_command: got en=%b we=%b addr=%h valid=%b want en=1 we=0 addr=0123 valid=0",
                     bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.disp_valid);
        end
        tick();
        #1;
        checks++;
        if ({bus_if.disp_valid, bus_if.disp_rdata, bus_if.cpu_valid} !== {1'b1, 8'h79, 1'b0}) begin
            errors++;
            $display("FAIL disp_return: got valid=%b data=%h cpu_valid=%b want valid=1 data=79 cpu_valid=0",
                     bus_if.disp_valid, bus_if.disp_rdata, bus_if.cpu_valid);
        end
        tick();
        #1;
        checks++;
        if (bus_if.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL disp_single_pulse: got %b want 0", bus_if.disp_valid);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_cpu_write_read();
        tick();
        bus_if.cpu_req   = 1'b1;
        bus_if.cpu_we    = 1'b1;
        bus_if.cpu_addr  = 15'h7FFF;
        bus_if.cpu_wdata = 8'hA5;
        #1;
        checks++;
        if (bus_if.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cpu_write_grant: got %b want 1", bus_if.cpu_gnt);
        end
        tick();
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_wdata = 8'h00;
        #1;
        checks++;
        if ({bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata} !== {2'b11, 15'h7FFF, 8'hA5}) begin
            errors++;
            $display("FAIL cpu_write_command: got en=%b we=%b addr=%h wdata=%h want en=1 we=1 addr=7fff wdata=a5",
                     bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata);
        end
        checks++;
        if (bus_if.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cpu_read_grant: got %b want 1", bus_if.cpu_gnt);
        end
        tick();
        bus_if.cpu_req = 1'b0;
        #1;
        checks++;
        if ({bus_if.mem_en, bus_if.mem_we, bus_if.cpu_valid} !== 3'b100) begin
            errors++;
            $display("FAIL cpu_read_cmd_no_write_valid: got en/we/valid=%b want 100",
                     {bus_if.mem_en, bus_if.mem_we, bus_if.cpu_valid});
        end
        tick();
        #1;
        checks++;
        if ({bus_if.cpu_valid, bus_if.cpu_rdata, bus_if.disp_valid} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL cpu_read_return: got valid=%b data=%h disp_valid=%b want valid=1 data=a5 disp_valid=0",
                     bus_if.cpu_valid, bus_if.cpu_rdata, bus_if.disp_valid);
        end
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Display holds the RAM for cycles 0..2 while the CPU read waits; the CPU
    // wins cycle 3. Returns: display data on 2..4, CPU data on 5.
    task automatic test_contention();
        logic [5:0]        exp_dg;
        logic [5:0]        exp_cg;
        logic [5:0]        exp_dv;
        logic [5:0]        exp_cv;
        logic [DATA_W-1:0] exp_dd [6];
        exp_dg = 6'b000111;
        exp_cg = 6'b001000;
        exp_dv = 6'b011100;
        exp_cv = 6'b100000;
        exp_dd = '{8'h00, 8'h00, 8'h5A, 8'h5B, 8'h58, 8'h00};

        bus_if.stat_clr = 1'b1;
        tick();
        bus_if.stat_clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            bus_if.disp_req  = (c < 3);
            bus_if.disp_addr = 15'h0100 + ADDR_W'(c);
            bus_if.cpu_req   = (c <= 3);
            bus_if.cpu_we    = 1'b0;
            bus_if.cpu_addr  = 15'h0010;
            #1;
            checks++;
            if ({bus_if.disp_gnt, bus_if.cpu_gnt} !== {exp_dg[c], exp_cg[c]}) begin
                errors++;
                $display("FAIL contention_grant cycle %0d: got %b%b want %b%b", c,
                         bus_if.disp_gnt, bus_if.cpu_gnt, exp_dg[c], exp_cg[c]);
            end
            checks++;
            if ({bus_if.disp_valid, bus_if.cpu_valid} !== {exp_dv[c], exp_cv[c]}) begin
                errors++;
                $display("FAIL contention_valid cycle %0d: got %b%b want %b%b", c,
                         bus_if.disp_valid, bus_if.cpu_valid, exp_dv[c], exp_cv[c]);
            end
            if (exp_dv[c]) begin
                checks++;
                if (bus_if.disp_rdata !== exp_dd[c]) begin
                    errors++;
                    $display("FAIL contention_disp_data cycle %0d: got %h want %h", c,
                             bus_if.disp_rdata, exp_dd[c]);
                end
            end
            if (exp_cv[c]) begin
                checks++;
                if (bus_if.cpu_rdata !== 8'h4A) begin
                    errors++;
                    $display("FAIL contention_cpu_data: got %h want 4a", bus_if.cpu_rdata);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus_if.stall_cnt !== 4'd3) begin
                    errors++;
                    $display("FAIL contention_stall_cnt: got %0d want 3", bus_if.stall_cnt);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_saturation();
        bus_if.stat_clr = 1'b1;
        bus_if.disp_req = 1'b1;
        bus_if.cpu_req  = 1'b1;
        tick();
        bus_if.stat_clr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            bus_if.disp_addr = ADDR_W'(i);
            if (i == 14) begin
                checks++;
                if (bus_if.stall_cnt !== 4'd14) begin
                    errors++;
                    $display("FAIL stall_count_14: got %0d want 14", bus_if.stall_cnt);
                end
            end
            if (i == 20) begin
                checks++;
                if (bus_if.stall_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL stall_saturate: got %0d want 15", bus_if.stall_cnt);
                end
            end
        end
        bus_if.stat_clr = 1'b1;
        tick();
        checks++;
        if (bus_if.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stall_clear_priority: got %0d want 0", bus_if.stall_cnt);
        end
        bus_if.stat_clr = 1'b0;
        tick();
        checks++;
        if (bus_if.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_after_clear: got %0d want 1", bus_if.stall_cnt);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_blank_only();
        bus_if.stat_clr = 1'b1;
        tick();
        bus_if.stat_clr   = 1'b0;
        bus_if.display_on = 1'b1;
        bus_if.cpu_req    = 1'b1;
        bus_if.cpu_we     = 1'b1;
        bus_if.cpu_addr   = 15'h0200;
        bus_if.cpu_wdata  = 8'h11;
        #1;
        checks++;
        if (bus_if.cpu_gnt !== ~c_BLANK_ONLY) begin
            errors++;
            $display("FAIL active_region_cpu_gnt: got %b want %b", bus_if.cpu_gnt, ~c_BLANK_ONLY);
        end
`ifdef VRAM_ARB_BLANK_ONLY_EN
        tick();
        checks++;
        if ({bus_if.cpu_gnt, bus_if.stall_cnt} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL active_region_stall: got gnt=%b cnt=%0d want gnt=0 cnt=1",
                     bus_if.cpu_gnt, bus_if.stall_cnt);
        end
        bus_if.display_on = 1'b0;
        #1;
        checks++;
        if (bus_if.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL blanking_cpu_gnt: got %b want 1", bus_if.cpu_gnt);
        end
`endif
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        tick();
        bus_if.disp_req  = 1'b1;
        bus_if.disp_addr = 15'h0123;
        bus_if.cpu_req   = 1'b1;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = 15'h0010;
        #1;
        checks++;
        if ({bus_if.disp_gnt, bus_if.cpu_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL arst_pre_grant: got %b want 10", {bus_if.disp_gnt, bus_if.cpu_gnt});
        end
        tick();
        bus_if.disp_req = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_if.mem_en, bus_if.disp_valid, bus_if.cpu_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL arst_clears: got en/valid/gnt=%b want 000",
                     {bus_if.mem_en, bus_if.disp_valid, bus_if.cpu_gnt});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus_if.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL arst_cpu_rearbitrate: got %b want 1", bus_if.cpu_gnt);
        end
        tick();
        bus_if.cpu_req = 1'b0;
        #1;
        checks++;
        if ({bus_if.disp_valid, bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr} !== {3'b010, 15'h0010}) begin
            errors++;
            $display("FAIL arst_drop_return: got dv=%b en=%b we=%b addr=%h want dv=0 en=1 we=0 addr=0010",
                     bus_if.disp_valid, bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr);
        end
        tick();
        #1;
        checks++;
        if ({bus_if.cpu_valid, bus_if.cpu_rdata, bus_if.disp_valid} !== {1'b1, 8'h4A, 1'b0}) begin
            errors++;
            $display("FAIL arst_cpu_return: got cv=%b data=%h dv=%b want cv=1 data=4a dv=0",
                     bus_if.cpu_valid, bus_if.cpu_rdata, bus_if.disp_valid);
        end
        idle_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        idle_inputs();

        test_reset();
        test_display_read();
        test_cpu_write_read();
        test_contention();
        test_saturation();
        test_blank_only();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
